// File: rtl/branch_stats_ctrl_pkg.sv
// Shared definitions for the branch-statistics controller: branch type codes,
// command opcodes, counter index map and FSM state encoding.
package branch_stats_ctrl_pkg;

    localparam logic [2:0] BR_NOBRANCH = 3'd0;
    localparam logic [2:0] BR_BEQ      = 3'd1;
    localparam logic [2:0] BR_BNE      = 3'd2;
    localparam logic [2:0] BR_BLT      = 3'd3;
    localparam logic [2:0] BR_BLTU     = 3'd4;
    localparam logic [2:0] BR_BGE      = 3'd5;
    localparam logic [2:0] BR_BGEU     = 3'd6;

    typedef enum logic [1:0] {
        OpNop   = 2'd0,
        OpClear = 2'd1,
        OpSnap  = 2'd2,
        OpRead  = 2'd3
    } stats_op_e;

    localparam int unsigned IDX_BR   = 0;
    localparam int unsigned IDX_MISS = 1;
    localparam int unsigned IDX_CYC  = 2;
    localparam int unsigned IDX_OVF  = 3;

    typedef enum logic {
        StIdle = 1'b0,
        StResp = 1'b1
    } state_e;

endpackage

// File: rtl/branch_stats_ctrl_if.sv
// Command/response channel between a debug/CSR requester and the stats controller.
interface branch_stats_ctrl_if #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned IDX_W = 2
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [IDX_W-1:0] cmd_idx;
    logic             resp_valid;
    logic             resp_ready;
    logic [CNT_W-1:0] resp_data;
    logic             resp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_idx, resp_ready,
        input  cmd_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_idx, resp_ready,
        output cmd_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/branch_stats_ctrl_stats_counter.sv
// Stats counter: wrapping CNT_W event counter with synchronous clear and a
// sticky overflow flag set on the wrap edge.
module branch_stats_ctrl_stats_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // Clear has priority over a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == '1) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/branch_stats_ctrl.sv
// Branch-statistics controller: live EX-stage event counters, atomic shadow
// snapshot and a two-state command/response sequencer for CSR readout.
module branch_stats_ctrl
    import branch_stats_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned IDX_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bubbleE,
    input  logic [2:0]          br_type,
    input  logic                brFlush,
    input  logic                count_en,
    branch_stats_ctrl_if.slave  csr
);

    state_e           state_q, state_d;
    logic             resp_valid_q, resp_valid_d;
    logic [CNT_W-1:0] resp_data_q, resp_data_d;
    logic             resp_err_q, resp_err_d;

    logic [CNT_W-1:0] live [3];
    logic [2:0]       ovf;
    logic [CNT_W-1:0] ovf_word;
    logic [CNT_W-1:0] shadow_q [4];

    logic             active, accept, clr, snap;
    stats_op_e        op;
    logic [IDX_W:0]   idx_ext;
    logic             rd_err;
    logic [CNT_W-1:0] rd_data;

    // Counting is independent of the command/response channels.
    assign active = count_en && !bubbleE;
    assign op     = stats_op_e'(csr.cmd_op);
    assign accept = csr.cmd_valid && (state_q == StIdle);
    assign clr    = accept && (op == OpClear);
    assign snap   = accept && (op == OpSnap);

    branch_stats_ctrl_stats_counter #(.CNT_W(CNT_W)) u_br (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (active && (br_type != BR_NOBRANCH)),
        .clr   (clr),
        .cnt   (live[IDX_BR]),
        .ovf   (ovf[IDX_BR])
    );

    branch_stats_ctrl_stats_counter #(.CNT_W(CNT_W)) u_miss (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (active && brFlush),
        .clr   (clr),
        .cnt   (live[IDX_MISS]),
        .ovf   (ovf[IDX_MISS])
    );

    branch_stats_ctrl_stats_counter #(.CNT_W(CNT_W)) u_cyc (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (active),
        .clr   (clr),
        .cnt   (live[IDX_CYC]),
        .ovf   (ovf[IDX_CYC])
    );

    assign ovf_word = {{(CNT_W-3){1'b0}}, ovf};

    // All four shadows load from pre-edge live values on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) shadow_q[k] <= '0;
        end else if (snap) begin
            shadow_q[IDX_BR]   <= live[IDX_BR];
            shadow_q[IDX_MISS] <= live[IDX_MISS];
            shadow_q[IDX_CYC]  <= live[IDX_CYC];
            shadow_q[IDX_OVF]  <= ovf_word;
        end
    end

    assign idx_ext = {1'b0, csr.cmd_idx};
    assign rd_err  = idx_ext > (IDX_W + 1)'(3);
    assign rd_data = rd_err ? '0 : shadow_q[csr.cmd_idx[1:0]];

    always_comb begin
        state_d      = state_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            StIdle: begin
                if (accept && (op != OpNop)) begin
                    state_d      = StResp;
                    resp_valid_d = 1'b1;
                    resp_data_d  = (op == OpRead) ? rd_data : '0;
                    resp_err_d   = (op == OpRead) && rd_err;
                end
            end
            StResp: begin
                if (csr.resp_ready) begin
                    state_d      = StIdle;
                    resp_valid_d = 1'b0;
                    resp_data_d  = '0;
                    resp_err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign csr.cmd_ready  = (state_q == StIdle);
    assign csr.resp_valid = resp_valid_q;
    assign csr.resp_data  = resp_data_q;
    assign csr.resp_err   = resp_err_q;

endmodule

// File: tb/tb_branch_stats_ctrl.sv
// Directed bench for branch_stats_ctrl: vector table for counting/snapshot/clear
// plus hand-written wrap, backpressure and mid-response reset sequences.
module tb_branch_stats_ctrl;
    import branch_stats_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       bubbleE;
    logic [2:0] br_type;
    logic       brFlush;
    logic       count_en;

    int n_vec = 0;
    int n_err = 0;

    branch_stats_ctrl_if #(.CNT_W(32), .IDX_W(2)) csr_if ();

    branch_stats_ctrl #(.CNT_W(32), .IDX_W(2)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bubbleE  (bubbleE),
        .br_type  (br_type),
        .brFlush  (brFlush),
        .count_en (count_en),
        .csr      (csr_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  br;
        logic        flush;
        logic        bub;
        logic [1:0]  op;
        logic [1:0]  idx;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [26];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Accept one command; pipeline events go idle after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [1:0] idx,
                         input logic [31:0] exp_data, input string nm);
        int n = 0;
        while (csr_if.cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_ready"}, {31'd0, csr_if.cmd_ready}, 32'd1);
        csr_if.cmd_valid = 1'b1;
        csr_if.cmd_op    = op;
        csr_if.cmd_idx   = idx;
        tick();
        csr_if.cmd_valid = 1'b0;
        br_type = BR_NOBRANCH;
        brFlush = 1'b0;
        bubbleE = 1'b1;
        if (op == OpNop) begin
            chk({nm, "_nop_novalid"}, {31'd0, csr_if.resp_valid}, 32'd0);
            chk({nm, "_nop_ready"}, {31'd0, csr_if.cmd_ready}, 32'd1);
        end else begin
            chk({nm, "_valid"}, {31'd0, csr_if.resp_valid}, 32'd1);
            chk({nm, "_data"}, csr_if.resp_data, exp_data);
            chk({nm, "_err"}, {31'd0, csr_if.resp_err}, 32'd0);
            csr_if.resp_ready = 1'b1;
            tick();
            csr_if.resp_ready = 1'b0;
            chk({nm, "_done"}, {31'd0, csr_if.resp_valid}, 32'd0);
        end
    endtask

    initial begin
        // Event cycles (op NOP) then SNAP/READ; expected values hand-counted.
        tbl[0]  = '{BR_BEQ,      1'b0, 1'b0, OpNop,   2'd0, 32'd0};
        tbl[1]  = '{BR_BNE,      1'b1, 1'b0, OpNop,   2'd0, 32'd0};
        tbl[2]  = '{BR_BLT,      1'b0, 1'b0, OpNop,   2'd0, 32'd0};
        tbl[3]  = '{BR_BGE,      1'b1, 1'b0, OpNop,   2'd0, 32'd0};
        tbl[4]  = '{BR_BEQ,      1'b0, 1'b0, OpNop,   2'd0, 32'd0};
        tbl[5]  = '{BR_BEQ,      1'b0, 1'b1, OpNop,   2'd0, 32'd0};
        tbl[6]  = '{BR_BEQ,      1'b0, 1'b1, OpNop,   2'd0, 32'd0};
        tbl[7]  = '{BR_BEQ,      1'b0, 1'b1, OpNop,   2'd0, 32'd0};
        tbl[8]  = '{BR_NOBRANCH, 1'b0, 1'b1, OpSnap,  2'd0, 32'd0};
        tbl[9]  = '{BR_NOBRANCH, 1'b0, 1'b1, OpRead,  2'd0, 32'd5};
        tbl[10] = '{BR_NOBRANCH, 1'b0, 1'b1, OpRead,  2'd1, 32'd2};
        tbl[11] = '{BR_NOBRANCH, 1'b0, 1'b1, OpRead,  2'd2, 32'd5};
        tbl[12] = '{BR_NOBRANCH, 1'b0, 1'b1, OpRead,  2'd3, 32'd0};
        tbl[13] = '{BR_BEQ,      1'b0, 1'b0, OpSnap,  2'd0, 32'd0};
        tbl[14] = '{BR_NOBRANCH, 1'b0, 1'b1, OpRead,  2'd0, 32'd5};
        tbl[15] = '{BR_NOBRANCH, 1'b0, 1'b1, OpRead,  2'd2, 32'd5};
        tbl[16] = '{BR_NOBRANCH, 1'b0, 1'b1, OpSnap,  2'd0, 32'd0};
        tbl[17] = '{BR_NOBRANCH, 1'b0, 1'b1, OpRead,  2'd0, 32'd6};
        tbl[18] = '{BR_NOBRANCH, 1'b0, 1'b1, OpRead,  2'd2, 32'd6};
        tbl[19] = '{BR_BEQ,      1'b1, 1'b0, OpClear, 2'd0, 32'd0};
        tbl[20] = '{BR_NOBRANCH, 1'b0, 1'b1, OpRead,  2'd1, 32'd2};
        tbl[21] = '{BR_NOBRANCH, 1'b0, 1'b1, OpRead,  2'd0, 32'd6};
        tbl[22] = '{BR_NOBRANCH, 1'b0, 1'b1, OpSnap,  2'd0, 32'd0};
        tbl[23] = '{BR_NOBRANCH, 1'b0, 1'b1, OpRead,  2'd1, 32'd0};
        tbl[24] = '{BR_NOBRANCH, 1'b0, 1'b1, OpRead,  2'd0, 32'd0};
        tbl[25] = '{BR_NOBRANCH, 1'b0, 1'b1, OpRead,  2'd2, 32'd0};

        rst_n = 1'b0;
        bubbleE = 1'b0;
        br_type = BR_BEQ;
        brFlush = 1'b1;
        count_en = 1'b0;
        csr_if.cmd_valid = 1'b0;
        csr_if.cmd_op = 2'd0;
        csr_if.cmd_idx = 2'd0;
        csr_if.resp_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset then idle with count_en low while the pipeline is busy.
        chk("rst_ready", {31'd0, csr_if.cmd_ready}, 32'd1);
        chk("rst_valid", {31'd0, csr_if.resp_valid}, 32'd0);
        chk("rst_data", csr_if.resp_data, 32'd0);
        chk("rst_err", {31'd0, csr_if.resp_err}, 32'd0);
        repeat (10) tick();
        chk("idle_ready", {31'd0, csr_if.cmd_ready}, 32'd1);
        chk("idle_valid", {31'd0, csr_if.resp_valid}, 32'd0);
        issue(OpSnap, 2'd0, 32'd0, "idle_snap");
        for (int i = 0; i < 4; i++) issue(OpRead, 2'(i), 32'd0, $sformatf("idle_rd%0d", i));
        issue(OpNop, 2'd0, 32'd0, "nop_cmd");

        count_en = 1'b1;
        for (int i = 0; i < 26; i++) begin
            br_type = tbl[i].br;
            brFlush = tbl[i].flush;
            bubbleE = tbl[i].bub;
            if (tbl[i].op == OpNop) tick();
            else issue(tbl[i].op, tbl[i].idx, tbl[i].exp, $sformatf("vec%0d", i));
        end
        bubbleE = 1'b1;
        br_type = BR_NOBRANCH;

        // Wrap: preload br counter to all-ones, then count one branch.
        count_en = 1'b0;
        force u_dut.u_br.cnt_d = 32'hFFFF_FFFF;
        tick();
        release u_dut.u_br.cnt_d;
        issue(OpSnap, 2'd0, 32'd0, "wrap_snap0");
        issue(OpRead, 2'd0, 32'hFFFF_FFFF, "wrap_pre");
        count_en = 1'b1;
        br_type = BR_BEQ;
        bubbleE = 1'b0;
        tick();
        br_type = BR_NOBRANCH;
        bubbleE = 1'b1;
        issue(OpSnap, 2'd0, 32'd0, "wrap_snap1");
        issue(OpRead, 2'd0, 32'd0, "wrap_br");
        issue(OpRead, 2'd3, 32'd1, "wrap_ovf");
        issue(OpRead, 2'd2, 32'd1, "wrap_cyc");
        issue(OpClear, 2'd0, 32'd0, "wrap_clr");
        issue(OpSnap, 2'd0, 32'd0, "wrap_snap2");
        issue(OpRead, 2'd3, 32'd0, "wrap_ovf_clr");

        // Three counted non-branch cycles, then READ under backpressure.
        bubbleE = 1'b0;
        repeat (3) tick();
        bubbleE = 1'b1;
        issue(OpSnap, 2'd0, 32'd0, "bp_snap");
        csr_if.cmd_valid = 1'b1;
        csr_if.cmd_op = OpRead;
        csr_if.cmd_idx = 2'd2;
        tick();
        csr_if.cmd_op = OpClear;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_valid%0d", i), {31'd0, csr_if.resp_valid}, 32'd1);
            chk($sformatf("bp_data%0d", i), csr_if.resp_data, 32'd3);
            chk($sformatf("bp_err%0d", i), {31'd0, csr_if.resp_err}, 32'd0);
            chk($sformatf("bp_ready%0d", i), {31'd0, csr_if.cmd_ready}, 32'd0);
            tick();
        end
        csr_if.cmd_valid = 1'b0;
        csr_if.resp_ready = 1'b1;
        tick();
        csr_if.resp_ready = 1'b0;
        chk("bp_done_valid", {31'd0, csr_if.resp_valid}, 32'd0);
        chk("bp_done_data", csr_if.resp_data, 32'd0);
        issue(OpSnap, 2'd0, 32'd0, "bp_resnap");
        issue(OpRead, 2'd2, 32'd3, "bp_clr_ignored");

        // Reset dropped mid-response.
        csr_if.cmd_valid = 1'b1;
        csr_if.cmd_op = OpRead;
        csr_if.cmd_idx = 2'd2;
        tick();
        csr_if.cmd_valid = 1'b0;
        chk("mr_valid_pre", {31'd0, csr_if.resp_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", {31'd0, csr_if.resp_valid}, 32'd0);
        chk("mr_ready", {31'd0, csr_if.cmd_ready}, 32'd1);
        chk("mr_data", csr_if.resp_data, 32'd0);
        tick();
        rst_n = 1'b1;
        issue(OpSnap, 2'd0, 32'd0, "mr_snap");
        for (int i = 0; i < 4; i++) issue(OpRead, 2'(i), 32'd0, $sformatf("mr_rd%0d", i));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
